// File: rtl/disp_pkg.sv
// Shared constants, state encoding and snapshot layout for the 7-segment scan multiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package disp_pkg;

    // Six display positions: sign, three max digits, two count digits.
    localparam int NUM_SLOTS = 6;
    localparam int SLOT_W    = 3;

    // Segment patterns, bit6 = segment g.
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_OFF   = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BLANK,
        SHOW
    } state_t;

    // One frame's worth of display data, captured together so a frame never tears.
    typedef struct packed {
        logic       sign;
        logic [6:0] max1;
        logic [6:0] max2;
        logic [6:0] max3;
        logic [6:0] num1;
        logic [6:0] num2;
    } snap_t;

    // One-hot digit enable for a slot index; bit0 is the sign position.
    function automatic logic [5:0] slot_onehot(input logic [SLOT_W-1:0] slot);
        slot_onehot = 6'b000001 << slot;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Per-slot cycle counter: wraps at PRESCALE-1 and flags the leading BLANK dead cycles.
// Latency: outputs decode the registered count directly (same cycle as the count).
// Backpressure: none; clr synchronously parks the count at 0.
module disp_prescaler #(
    parameter int PRESCALE = 8,
    parameter int BLANK    = 1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    output logic tick,
    output logic blank,
    output logic blank_end
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_C    = CNT_W'(BLANK);
    // Only meaningful when BLANK > 0; gated below.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count up through the slot, wrapping on the terminal count; clr wins.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick      = (count_q == CNT_LAST);
    assign blank     = (count_q < BLANK_C);
    assign blank_end = (BLANK > 0) && (count_q == BLANK_LAST);

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexes sign + five digit codes onto one segment bus with one-hot digit select; frame-snapshotted inputs.
// Latency: all outputs registered, one cycle behind the FSM state; first FRAME 2 cycles after ENABLE is sampled.
// Backpressure: none; ENABLE=0 parks the scanner and blanks outputs. Optional blink via DISP_SCAN_MUX_BLINK_EN.
module disp_scan_mux #(
    parameter int PRESCALE = 8,
    parameter int BLANK    = 1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       BLINK,
    input  logic       SIGN,
    input  logic [6:0] DISPMAX1,
    input  logic [6:0] DISPMAX2,
    input  logic [6:0] DISPMAX3,
    input  logic [6:0] DISPNUM1,
    input  logic [6:0] DISPNUM2,
    output logic [6:0] SEG,
    output logic [5:0] DIG,
    output logic       FRAME
);

    import disp_pkg::*;

    // The BLANK parameter shadows the state literal of the same name, so the
    // state is always referenced with its package scope below.

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    snap_t              snap_q, snap_d;

    logic [6:0]         seg_q, seg_d;
    logic [5:0]         dig_q, dig_d;
    logic               frame_q, frame_d;

    logic               pre_clr;
    logic               pre_tick;
    logic               pre_blank;
    logic               pre_blank_end;
    logic [6:0]         slot_code;

    // Counter restarts whenever the scanner is parked, so LOAD always sits on count 0.
    assign pre_clr = !ENABLE || (state_q == IDLE);

    disp_prescaler #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_prescaler (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .clr       (pre_clr),
        .tick      (pre_tick),
        .blank     (pre_blank),
        .blank_end (pre_blank_end)
    );

    // Next-state, slot and snapshot logic.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        snap_d  = snap_q;
        if (!ENABLE) begin
            // Park immediately; the snapshot is deliberately kept.
            state_d = IDLE;
            slot_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    snap_d = '{sign: SIGN, max1: DISPMAX1, max2: DISPMAX2,
                               max3: DISPMAX3, num1: DISPNUM1, num2: DISPNUM2};
                    slot_d = '0;
                    // LOAD is cycle 0 of slot 0 and already counts as a dead cycle.
                    state_d = (BLANK > 1) ? disp_pkg::BLANK : SHOW;
                end
                disp_pkg::BLANK: begin
                    if (pre_blank_end) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (pre_tick) begin
                        if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
                            state_d = LOAD;
                            slot_d  = '0;
                        end else begin
                            slot_d  = slot_q + SLOT_W'(1);
                            state_d = (BLANK > 0) ? disp_pkg::BLANK : SHOW;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Segment code for the slot currently being shown.
    always_comb begin
        slot_code = SEG_OFF;
        case (slot_q)
            3'd0:    slot_code = snap_q.sign ? SEG_MINUS : SEG_OFF;
            3'd1:    slot_code = snap_q.max1;
            3'd2:    slot_code = snap_q.max2;
            3'd3:    slot_code = snap_q.max3;
            3'd4:    slot_code = snap_q.num1;
            3'd5:    slot_code = snap_q.num2;
            default: slot_code = SEG_OFF;
        endcase
    end

`ifdef DISP_SCAN_MUX_BLINK_EN
    logic [4:0] frm_cnt_q, frm_cnt_d;
    logic       blink_dark_q, blink_dark_d;

    // Frame counter: bumps on each LOAD; the current frame's index bit4 is latched
    // at LOAD so frames 16..31 of each 32 are the dark half of the blink.
    always_comb begin
        frm_cnt_d    = frm_cnt_q;
        blink_dark_d = blink_dark_q;
        if (!ENABLE || (state_q == IDLE)) begin
            frm_cnt_d    = '0;
            blink_dark_d = 1'b0;
        end else if (state_q == LOAD) begin
            frm_cnt_d    = frm_cnt_q + 5'd1;
            blink_dark_d = frm_cnt_q[4];
        end
    end

    // Blink frame counter registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            frm_cnt_q    <= '0;
            blink_dark_q <= 1'b0;
        end else begin
            frm_cnt_q    <= frm_cnt_d;
            blink_dark_q <= blink_dark_d;
        end
    end
`else
    // Blink support compiled out; the request pin is intentionally ignored.
    logic unused_blink;
    assign unused_blink = BLINK;
`endif

    // Output decode, registered so no input reaches an output combinationally.
    always_comb begin
        seg_d   = SEG_OFF;
        dig_d   = '0;
        frame_d = 1'b0;
        if (ENABLE) begin
            frame_d = (state_q == LOAD);
            if ((state_q == SHOW) && !pre_blank) begin
                dig_d = slot_onehot(slot_q);
                seg_d = slot_code;
            end
`ifdef DISP_SCAN_MUX_BLINK_EN
            if (BLINK && blink_dark_q) begin
                dig_d = '0;
            end
`endif
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            slot_q  <= '0;
            snap_q  <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign DIG   = dig_q;
    assign FRAME = frame_q;

endmodule

// File: doc/disp_scan_mux.md
# disp_scan_mux

Time-multiplexed 7-segment driver placed directly downstream of the peak-count/maximum scanner. It consumes the scanner's five parallel 7-bit digit codes and its SIGN flag. It drives them onto one shared segment bus with a one-hot digit select, six positions per frame. Inputs are snapshotted once per frame, so a scan that updates mid-frame never tears the display.

## Interface
- PRESCALE, 8: clock cycles per digit slot; legal range 2..65535.
- BLANK, 1: dead cycles at the start of each slot (DIG forced 0); legal range 0..PRESCALE-1.
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = scan; 0 = display off and scanner parked.
- BLINK  in  1  blink request; used only when the blink macro is defined, otherwise ignored.
- SIGN  in  1  sign flag from the scanner.
- DISPMAX1, DISPMAX2, DISPMAX3  in  7 each  max digit codes, hundreds/tens/units.
- DISPNUM1, DISPNUM2  in  7 each  count digit codes, tens/units.
- SEG  out  7  segment pattern for the active digit, bit6 = segment g.
- DIG  out  6  one-hot digit enable, active-high; bit0 = sign position.
- FRAME  out  1  one-cycle pulse on the cycle the snapshot is taken.

## Operation
- Reset values: SEG=0, DIG=0, FRAME=0. State IDLE. Prescaler, slot and frame counters 0. All snapshot registers 0.
- FSM states:
  - IDLE: outputs 0. If ENABLE=1, go to LOAD next cycle.
  - LOAD: capture all six inputs into the snapshot; FRAME=1 for this cycle; slot=0. Go to BLANK, or to SHOW if BLANK=0.
  - BLANK: DIG=0, SEG=0 for BLANK cycles, then go to SHOW.
  - SHOW: DIG=1<<slot; SEG=snapshot code for the slot. At slot end:
    - if slot<5, slot+1 and go to BLANK/SHOW;
    - if slot==5, go to LOAD.
- Slot order is 0 sign, 1 DISPMAX1, 2 DISPMAX2, 3 DISPMAX3, 4 DISPNUM1, 5 DISPNUM2.
- Sign slot: SEG=7'b1000000 (minus) when the snapshot SIGN=1, else 7'b0000000.
- Prescaler counts 0..PRESCALE-1 inside each slot; the LOAD cycle is counted as cycle 0 of slot 0. Counter width is $clog2(PRESCALE).
- ENABLE=0 in any state: go to IDLE on the next edge. All outputs are 0 from that edge. Counters clear. Snapshot registers are held.
- Input changes after LOAD have no effect until the next LOAD.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Frame length is exactly 6*PRESCALE cycles; LOAD recurs every 6*PRESCALE cycles while ENABLE=1.
- Each slot: first BLANK cycles DIG=0, remaining PRESCALE-BLANK cycles DIG one-hot. Slot 0's blank window includes the LOAD cycle.
- First FRAME pulse: 2 cycles after ENABLE is sampled 1 (IDLE→LOAD edge, then the registered pulse).
- DIG never has more than one bit set. DIG changes only through an all-zero cycle when BLANK≥1.
- RESET asserted mid-frame: outputs are 0 immediately (asynchronous). After release, restart from IDLE.
- ENABLE and RESET together: RESET wins.

## Configuration
- DISP_SCAN_MUX_BLINK_EN defined:
  - a 5-bit frame counter increments on every LOAD and wraps;
  - while BLINK=1 and frame counter bit4=1, DIG is forced to 0; SEG still updates;
  - the frame counter clears in IDLE.
- Not defined: BLINK is ignored and there is no frame counter.

## Structure
- Shared package disp_pkg:
  - segment constants SEG_MINUS=7'b1000000 and SEG_OFF=7'b0000000;
  - state enum {IDLE, LOAD, BLANK, SHOW};
  - NUM_SLOTS=6.
- One sub-module, disp_prescaler: a parameterized terminal-count counter with sync clear, giving a tick at PRESCALE-1 and a flag for count<BLANK.

## Test plan
- PRESCALE=4, BLANK=1; reset, then ENABLE=1 with SIGN=0, DISPMAX*=7'b0011000, DISPNUM*=7'b1111110 -> FRAME pulses at cycle 2 and every 24 cycles; DIG sequence per slot is 0,1,1,1 cycles of 6'b000001 … 6'b100000; sign slot SEG=0.
- SIGN=1 -> sign slot SEG=7'b1000000.
- Change DISPMAX2 to 7'b1111111 mid-frame -> slot 2 shows the old code until after the next FRAME pulse.
- ENABLE dropped during slot 3 -> DIG=0 and SEG=0 next cycle. Re-enable -> fresh LOAD and restart at slot 0.
- RESET pulsed mid-SHOW -> outputs 0 asynchronously, state IDLE, no FRAME pulse until ENABLE is seen again.
- With DISP_SCAN_MUX_BLINK_EN and BLINK=1 -> frames 16..31 have DIG always 0 and frames 0..15 are normal. Without the macro, all frames are normal.
